mem_stage: RTL and testbench

MEM pipeline stage. Consumes the 106-bit EX_MEM register and performs the data-memory access over a req/ack data bus. Produces the MEM_WB register and the MEM-side forwarding signals. Raises MEM_Stall while a bus access is outstanding; a bus timeout converts the access into a bubble and sets a sticky error flag.

---
 rtl/mem_stage_pkg.sv | 46 ++++
 rtl/mem_stage_if.sv | 24 ++
 rtl/mem_bus_ctrl.sv | 93 +++++++++
 rtl/mem_stage.sv | 104 ++++++++++
 tb/tb_mem_stage.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared field positions, encodings and FSM states for the
// MEM pipeline stage (mem_stage, mem_bus_ctrl).
package mem_stage_pkg;

    localparam int EXMEM_W = 106;
    localparam int MEMWB_W = 38;

    // EX_MEM field positions
    localparam int EX_SD_LSB    = 0;    // [31:0]   store data
    localparam int EX_ALU_LSB   = 32;   // [63:32]  ALU result / address
    localparam int EX_WREG_LSB  = 64;   // [68:64]  write register
    localparam int EX_MEMREAD   = 69;
    localparam int EX_MEMWRITE  = 70;
    localparam int EX_REGWRITE  = 71;
    localparam int EX_MTR_LSB   = 72;   // [73:72]  MemtoReg
    localparam int EX_PC4_LSB   = 74;   // [105:74] PC_plus4

    // MEM_WB field positions
    localparam int WB_DATA_LSB  = 0;    // [31:0]   RegWriteData
    localparam int WB_WREG_LSB  = 32;   // [36:32]  WriteRegister
    localparam int WB_REGWRITE  = 37;

    // MemtoReg encodings; 2'b11 falls back to the ALU result
    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC4 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } busState_t;

    // Assemble a MEM_WB word from its fields.
    function automatic logic [MEMWB_W-1:0] packMemWb(input logic regWrite,
                                                     input logic [4:0] writeReg,
                                                     input logic [31:0] data);
        logic [MEMWB_W-1:0] w;
        w = '0;
        w[WB_DATA_LSB +: 32] = data;
        w[WB_WREG_LSB +: 5]  = writeReg;
        w[WB_REGWRITE]       = regWrite;
        return w;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory bus between the MEM stage (master) and memory (slave).
//
// Handshake: the master holds dbus_req high together with stable dbus_we,
// dbus_addr and dbus_wdata until the slave returns dbus_ack for one cycle.
// The transfer completes in the cycle where dbus_req && dbus_ack; dbus_rdata
// is only meaningful in that cycle. dbus_ack while dbus_req is low is ignored.
interface mem_stage_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_wdata,
        input  dbus_ack, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_wdata,
        output dbus_ack, dbus_rdata
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: bus access FSM (IDLE/WAIT/ERR), wait-state counter with
// timeout, request and stall generation, sticky bus-error flag.
module mem_bus_ctrl
    import mem_stage_pkg::*;
#(
    parameter int DBUS_TIMEOUT = 255
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      access,     // an access is to be issued this cycle
    input  logic      ack,
    output logic      busReq,
    output logic      memStall,
    output logic      capture,    // MEM_WB takes the stage result (else bubble)
    output logic      busErr,
    output busState_t dbgState
);

    localparam logic [9:0] TIMEOUT_C = 10'(DBUS_TIMEOUT);

    busState_t  state, stateNext;
    logic [9:0] waitCnt, waitCntNext;
    logic       busErrNext;
    logic       hit;

    assign hit      = access & ack;
    assign dbgState = state;

    // State, counter and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            waitCnt <= '0;
            busErr  <= 1'b0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            busErr  <= busErrNext;
        end
    end

    // Next state, counter update and bus/stall outputs.
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        busErrNext  = busErr;
        busReq      = 1'b0;
        memStall    = 1'b0;
        capture     = 1'b0;
        case (state)
            ST_IDLE: begin
                busReq   = access;
                memStall = access & ~ack;
                capture  = ~access | ack;
                if (access && !ack) begin
                    stateNext   = ST_WAIT;
                    waitCntNext = 10'd1;
                end
            end
            ST_WAIT: begin
                busReq   = access;
                memStall = access & ~ack;
                if (hit) begin
                    capture     = 1'b1;
                    stateNext   = ST_IDLE;
                    waitCntNext = '0;
                end else if (waitCnt == TIMEOUT_C) begin
                    stateNext   = ST_ERR;
                    busErrNext  = 1'b1;
                    waitCntNext = '0;
                end else begin
                    waitCntNext = waitCnt + 10'd1;
                end
            end
            ST_ERR: begin
                // Abandoned access: let the instruction leave as a bubble.
                stateNext   = ST_IDLE;
                waitCntNext = '0;
            end
            default: begin
                stateNext   = ST_IDLE;
                waitCntNext = '0;
            end
        endcase
        // Reset aborts any outstanding access in the same cycle.
        if (rst) begin
            busReq   = 1'b0;
            memStall = 1'b0;
            capture  = 1'b0;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Issues the data-memory access described by
// EX_MEM, stalls upstream while it is outstanding, selects the register
// write-back value, drives MEM-side forwarding and registers MEM_WB.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned accesses are dropped
// as bubbles and flagged on MEM_AlignErr.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DBUS_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [EXMEM_W-1:0]   EX_MEM,
    mem_stage_if.master          dbus,
    output logic                 MEM_Stall,
    output logic                 MEM_RegWrite,
    output logic [4:0]           MEM_WriteRegister,
    output logic [31:0]          MEM_RegWriteData,
    output logic                 MEM_BusErr,
    output logic [MEMWB_W-1:0]   MEM_WB,
`ifdef MEM_ALIGN_CHECK_EN
    output logic                 MEM_AlignErr,
`endif
    output logic [1:0]           MEM_State      // bus FSM state, for debug
);

    logic [31:0] storeData, aluResult, pcPlus4;
    logic [4:0]  writeReg;
    logic [1:0]  memToReg;
    logic        memRead, memWrite, regWrite;
    logic        access, misaligned, issue, ackEff, capture;
    logic [31:0] regWriteData;
    busState_t   busState;

    assign storeData = EX_MEM[EX_SD_LSB +: 32];
    assign aluResult = EX_MEM[EX_ALU_LSB +: 32];
    assign writeReg  = EX_MEM[EX_WREG_LSB +: 5];
    assign memRead   = EX_MEM[EX_MEMREAD];
    assign memWrite  = EX_MEM[EX_MEMWRITE];
    assign regWrite  = EX_MEM[EX_REGWRITE];
    assign memToReg  = EX_MEM[EX_MTR_LSB +: 2];
    assign pcPlus4   = EX_MEM[EX_PC4_LSB +: 32];

    // Read and write together count as a write through dbus_we.
    assign access = memRead | memWrite;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned   = access & (aluResult[1:0] != 2'b00);
    assign MEM_AlignErr = misaligned & ~rst;
`else
    assign misaligned   = 1'b0;
`endif
    assign issue = access & ~misaligned;

    // Address and data come straight from EX_MEM, which upstream holds while stalled.
    assign dbus.dbus_we    = memWrite;
    assign dbus.dbus_addr  = aluResult;
    assign dbus.dbus_wdata = storeData;

    mem_bus_ctrl #(
        .DBUS_TIMEOUT(DBUS_TIMEOUT)
    ) u_bus_ctrl (
        .clk      (clk),
        .rst      (rst),
        .access   (issue),
        .ack      (dbus.dbus_ack),
        .busReq   (dbus.dbus_req),
        .memStall (MEM_Stall),
        .capture  (capture),
        .busErr   (MEM_BusErr),
        .dbgState (busState)
    );

    assign MEM_State = busState;
    assign ackEff    = dbus.dbus_ack & dbus.dbus_req;

    // Write-back value select.
    always_comb begin
        regWriteData = aluResult;
        case (memToReg)
            MTR_ALU: regWriteData = aluResult;
            MTR_MEM: regWriteData = dbus.dbus_rdata;
            MTR_PC4: regWriteData = pcPlus4;
            default: regWriteData = aluResult;
        endcase
    end

    // A load is only forwarded once its data is on the bus.
    assign MEM_RegWrite      = regWrite & ~(memRead & ~ackEff);
    assign MEM_WriteRegister = writeReg;
    assign MEM_RegWriteData  = regWriteData;

    // MEM_WB register: result on completion, bubble otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            MEM_WB <= '0;
        end else if (capture && !misaligned) begin
            MEM_WB <= packMemWb(regWrite, writeReg, regWriteData);
        end else begin
            MEM_WB <= '0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven single-cycle vectors plus hand-written
// multi-cycle sequences (wait states, timeout, reset during WAIT).
module tb_mem_stage;

    localparam int TMO = 4;

    typedef struct {
        logic [105:0] ex;
        logic         ack;
        logic [31:0]  rdata;
        logic         eReq;
        logic         eWe;
        logic         eStall;
        logic         eFwd;
        logic [31:0]  eData;
        logic [37:0]  eWb;
    } vec_t;

    logic         clk;
    logic         rst;
    logic [105:0] ex_mem;
    logic         mem_stall;
    logic         mem_reg_write;
    logic [4:0]   mem_write_register;
    logic [31:0]  mem_reg_write_data;
    logic         mem_bus_err;
    logic [37:0]  mem_wb;
    logic [1:0]   mem_state;
`ifdef MEM_ALIGN_CHECK_EN
    logic         mem_align_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [37:0] exp_q[$];
    vec_t vecs[9];

    mem_stage_if dbus_ifc();

    mem_stage #(
        .DBUS_TIMEOUT(TMO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .EX_MEM            (ex_mem),
        .dbus              (dbus_ifc.master),
        .MEM_Stall         (mem_stall),
        .MEM_RegWrite      (mem_reg_write),
        .MEM_WriteRegister (mem_write_register),
        .MEM_RegWriteData  (mem_reg_write_data),
        .MEM_BusErr        (mem_bus_err),
        .MEM_WB            (mem_wb),
`ifdef MEM_ALIGN_CHECK_EN
        .MEM_AlignErr      (mem_align_err),
`endif
        .MEM_State         (mem_state)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [105:0] mk(input logic [31:0] pc4, input logic [1:0] mtr,
                                        input logic rw, input logic mw, input logic mr,
                                        input logic [4:0] wreg, input logic [31:0] alu,
                                        input logic [31:0] sd);
        return {pc4, mtr, rw, mw, mr, wreg, alu, sd};
    endfunction

    function automatic logic [37:0] wb(input logic rw, input logic [4:0] r, input logic [31:0] d);
        return {rw, r, d};
    endfunction

    function automatic vec_t mkv(input logic [105:0] ex, input logic ack, input logic [31:0] rdata,
                                 input logic eReq, input logic eWe, input logic eStall,
                                 input logic eFwd, input logic [31:0] eData, input logic [37:0] eWb);
        vec_t v;
        v.ex = ex; v.ack = ack; v.rdata = rdata;
        v.eReq = eReq; v.eWe = eWe; v.eStall = eStall; v.eFwd = eFwd;
        v.eData = eData; v.eWb = eWb;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // One clock of the stage: combinational outputs at negedge, MEM_WB after the edge.
    task automatic run_cycle(input string name, input logic e_req, input logic e_we,
                             input logic e_stall, input logic e_fwd, input logic [31:0] e_data,
                             input logic e_err, input logic [37:0] e_wb);
        logic [37:0] exp_wb;
        @(negedge clk);
        check({name, "/req"},   64'(dbus_ifc.dbus_req), 64'(e_req));
        check({name, "/we"},    64'(dbus_ifc.dbus_we),  64'(e_we));
        check({name, "/stall"}, 64'(mem_stall),         64'(e_stall));
        check({name, "/fwd"},   64'(mem_reg_write),     64'(e_fwd));
        check({name, "/fdata"}, 64'(mem_reg_write_data), 64'(e_data));
        check({name, "/freg"},  64'(mem_write_register), 64'(ex_mem[68:64]));
        check({name, "/err"},   64'(mem_bus_err),       64'(e_err));
        if (e_req) begin
            check({name, "/addr"},  64'(dbus_ifc.dbus_addr),  64'(ex_mem[63:32]));
            check({name, "/wdata"}, 64'(dbus_ifc.dbus_wdata), 64'(ex_mem[31:0]));
        end
        exp_q.push_back(e_wb);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s/wb: got empty queue required entry", name);
        end else begin
            exp_wb = exp_q.pop_front();
            check({name, "/wb"}, 64'(mem_wb), 64'(exp_wb));
        end
    endtask

    initial begin
        logic [31:0] r;
        r = $urandom;

        vecs[0] = mkv(mk(32'h4, 2'b01, 1, 0, 1, 5'd8, 32'h10, 32'h0), 1, 32'hDEADBEEF,
                      1, 0, 0, 1, 32'hDEADBEEF, wb(1, 5'd8, 32'hDEADBEEF));
        vecs[1] = mkv(mk(32'h0040_0008, 2'b10, 1, 0, 0, 5'd31, 32'h1234, 32'h0), 0, 32'h0,
                      0, 0, 0, 1, 32'h0040_0008, wb(1, 5'd31, 32'h0040_0008));
        vecs[2] = mkv(mk(32'h100, 2'b00, 1, 0, 0, 5'd5, 32'hCAFE_0001, 32'h55), 0, 32'h1111,
                      0, 0, 0, 1, 32'hCAFE_0001, wb(1, 5'd5, 32'hCAFE_0001));
        vecs[3] = mkv(mk(32'h200, 2'b11, 1, 0, 0, 5'd7, 32'hA5A5_A5A5, 32'h0), 0, 32'h2222,
                      0, 0, 0, 1, 32'hA5A5_A5A5, wb(1, 5'd7, 32'hA5A5_A5A5));
        vecs[4] = mkv(mk(32'h300, 2'b00, 0, 1, 0, 5'd3, 32'h20, 32'h1234_5678), 1, 32'h0,
                      1, 1, 0, 0, 32'h20, wb(0, 5'd3, 32'h20));
        vecs[5] = mkv(mk(32'h304, 2'b00, 0, 1, 1, 5'd4, 32'h24, 32'hFEED_F00D), 1, 32'h9999,
                      1, 1, 0, 0, 32'h24, wb(0, 5'd4, 32'h24));
        vecs[6] = mkv(mk(32'h308, 2'b00, 1, 0, 0, 5'd0, 32'h77, 32'h0), 0, 32'h0,
                      0, 0, 0, 1, 32'h77, wb(1, 5'd0, 32'h77));
        vecs[7] = mkv(mk(32'h30C, 2'b00, 1, 0, 0, 5'd12, 32'h1357, 32'h0), 1, 32'hBADB_AD00,
                      0, 0, 0, 1, 32'h1357, wb(1, 5'd12, 32'h1357));
        vecs[8] = mkv(mk(32'h310, 2'b01, 1, 0, 1, 5'd20, 32'h100, 32'h0), 1, r,
                      1, 0, 0, 1, r, wb(1, 5'd20, r));

        // Reset with a load and a stray ack presented: no request, no stall.
        rst = 1'b1;
        ex_mem = mk(32'h0, 2'b01, 1, 0, 1, 5'd8, 32'h10, 32'h0);
        dbus_ifc.dbus_ack   = 1'b1;
        dbus_ifc.dbus_rdata = 32'h5555_AAAA;
        run_cycle("reset", 0, 0, 0, 0, 32'h5555_AAAA, 0, 38'h0);
        rst = 1'b0;

        // Single-cycle vectors, all completing from IDLE.
        for (int i = 0; i < 9; i++) begin
            ex_mem              = vecs[i].ex;
            dbus_ifc.dbus_ack   = vecs[i].ack;
            dbus_ifc.dbus_rdata = vecs[i].rdata;
            run_cycle($sformatf("vec%0d", i), vecs[i].eReq, vecs[i].eWe, vecs[i].eStall,
                      vecs[i].eFwd, vecs[i].eData, 0, vecs[i].eWb);
        end

        // Store with three wait states.
        ex_mem = mk(32'h400, 2'b00, 0, 1, 0, 5'd6, 32'h20, 32'h1234_5678);
        dbus_ifc.dbus_ack = 1'b0;
        for (int i = 0; i < 3; i++)
            run_cycle($sformatf("st_wait%0d", i), 1, 1, 1, 0, 32'h20, 0, 38'h0);
        dbus_ifc.dbus_ack = 1'b1;
        run_cycle("st_ack", 1, 1, 0, 0, 32'h20, 0, wb(0, 5'd6, 32'h20));

        // Load with two wait states: no forwarding until data arrives.
        ex_mem = mk(32'h404, 2'b01, 1, 0, 1, 5'd9, 32'h30, 32'h0);
        dbus_ifc.dbus_ack   = 1'b0;
        dbus_ifc.dbus_rdata = 32'h0BAD_F00D;
        for (int i = 0; i < 2; i++)
            run_cycle($sformatf("ld_wait%0d", i), 1, 0, 1, 0, 32'h0BAD_F00D, 0, 38'h0);
        dbus_ifc.dbus_ack   = 1'b1;
        dbus_ifc.dbus_rdata = 32'hC0FF_EE11;
        run_cycle("ld_ack", 1, 0, 0, 1, 32'hC0FF_EE11, 0, wb(1, 5'd9, 32'hC0FF_EE11));

        // Timeout: IDLE cycle plus TMO wait states stall, then one ERR cycle.
        ex_mem = mk(32'h408, 2'b01, 1, 0, 1, 5'd13, 32'h40, 32'h0);
        dbus_ifc.dbus_ack   = 1'b0;
        dbus_ifc.dbus_rdata = 32'h0BAD_0BAD;
        for (int i = 0; i <= TMO; i++)
            run_cycle($sformatf("tmo_stall%0d", i), 1, 0, 1, 0, 32'h0BAD_0BAD, 0, 38'h0);
        run_cycle("tmo_err", 0, 0, 0, 0, 32'h0BAD_0BAD, 1, 38'h0);
        ex_mem = mk(32'h500, 2'b00, 1, 0, 0, 5'd14, 32'h2468, 32'h0);
        run_cycle("tmo_after", 0, 0, 0, 1, 32'h2468, 1, wb(1, 5'd14, 32'h2468));

        // Reset in WAIT: request drops at once, nothing written, error cleared.
        ex_mem = mk(32'h504, 2'b01, 1, 0, 1, 5'd15, 32'h80, 32'h0);
        dbus_ifc.dbus_ack   = 1'b0;
        dbus_ifc.dbus_rdata = 32'h1234_0000;
        run_cycle("rw_idle", 1, 0, 1, 0, 32'h1234_0000, 1, 38'h0);
        run_cycle("rw_wait", 1, 0, 1, 0, 32'h1234_0000, 1, 38'h0);
        rst = 1'b1;
        run_cycle("rw_rst", 0, 0, 0, 0, 32'h1234_0000, 1, 38'h0);
        rst = 1'b0;
        ex_mem = mk(32'h508, 2'b00, 1, 0, 0, 5'd16, 32'h1357, 32'h0);
        dbus_ifc.dbus_ack = 1'b1;
        run_cycle("rw_late_ack", 0, 0, 0, 1, 32'h1357, 0, wb(1, 5'd16, 32'h1357));

        // Back in IDLE: a new load without ack stalls immediately.
        ex_mem = mk(32'h50C, 2'b01, 1, 0, 1, 5'd17, 32'h90, 32'h0);
        dbus_ifc.dbus_ack = 1'b0;
        run_cycle("rw_new_ld", 1, 0, 1, 0, 32'h1234_0000, 0, 38'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
